// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the floating-point pre-add datapath.
//   - aligner_state_t : aligner FSM state encoding
//   - aligned_width() : width of an aligned mantissa, {hidden, fraction, G, R, S}
//   - GRS bit indices inside an aligned mantissa
// -----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } aligner_state_t;

    // Guard, round and sticky occupy the three LSBs of an aligned mantissa.
    localparam int GRS_BITS   = 3;
    localparam int GUARD_BIT  = 2;
    localparam int ROUND_BIT  = 1;
    localparam int STICKY_BIT = 0;

    // Hidden bit + stored fraction + G/R/S.
    function automatic int aligned_width(input int mantissa_size);
        return mantissa_size + 1 + GRS_BITS;
    endfunction

endpackage : fpu_pkg

// File: rtl/fpu_sticky_shifter.sv
// -----------------------------------------------------------------------------
// fpu_sticky_shifter
// Combinational logical right shift of a W-bit aligned mantissa. Every bit that
// falls off the bottom is OR-ed into bit 0, so the LSB keeps acting as sticky.
// An amount of W or more yields zero except for the sticky bit.
// Ports:
//   value  [W-1:0]     vector to shift
//   amount [AMT_W-1:0] shift distance
//   result [W-1:0]     shifted vector with sticky folded into bit 0
// -----------------------------------------------------------------------------
module fpu_sticky_shifter
    import fpu_pkg::*;
#(
    parameter int W     = 27,
    parameter int AMT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    input  logic [AMT_W-1:0] amount,
    output logic [W-1:0]     result
);

    logic [W-1:0] lost_mask;
    logic         sticky;

    always_comb begin
        // Ones in exactly the positions that are shifted out; all ones once
        // amount >= W because the left shift then clears the whole vector.
        lost_mask          = ~({W{1'b1}} << amount);
        sticky             = |(value & lost_mask);
        result             = value >> amount;
        result[STICKY_BIT] = result[STICKY_BIT] | sticky;
    end

endmodule : fpu_sticky_shifter

// File: rtl/fpu_aligner.sv
// -----------------------------------------------------------------------------
// fpu_aligner
// Pre-add exponent aligner. Accepts two unpacked operands (hidden bit explicit),
// selects the one with the larger exponent and right-shifts the other mantissa
// by the exponent difference (clamped to W), preserving G/R/S.
// Build option:
//   FPU_ALIGNER_BARREL_EN : shift done in one cycle inside COMPARE (no SHIFT
//                           state, Shift_Step unused). Default: iterative,
//                           up to Shift_Step bits per SHIFT cycle.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           operand handshake (accepted only in IDLE)
//   a_mantissa, a_exponent        operand A, {hidden, fraction}
//   b_mantissa, b_exponent        operand B, {hidden, fraction}
//   out_valid / out_ready         result handshake (outputs held while stalled)
//   big_mantissa                  larger-exponent operand, {mant, 3'b000}
//   small_mantissa                aligned operand, {mant, G, R, S}
//   common_exponent               max(a_exponent, b_exponent)
//   swapped                       B had the strictly larger exponent
// -----------------------------------------------------------------------------
module fpu_aligner
    import fpu_pkg::*;
#(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int Shift_Step    = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [Mantissa_Size:0]                   a_mantissa,
    input  logic [Exponent_Size-1:0]                 a_exponent,
    input  logic [Mantissa_Size:0]                   b_mantissa,
    input  logic [Exponent_Size-1:0]                 b_exponent,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [aligned_width(Mantissa_Size)-1:0]  big_mantissa,
    output logic [aligned_width(Mantissa_Size)-1:0]  small_mantissa,
    output logic [Exponent_Size-1:0]                 common_exponent,
    output logic                                     swapped
);

    localparam int W      = aligned_width(Mantissa_Size);
    localparam int AMT_W  = $clog2(W + 1);
    localparam int DIFF_W = Exponent_Size + 1;

    aligner_state_t         state_q, state_d;

    logic [Mantissa_Size:0] a_mant_q, b_mant_q;
    logic [Exponent_Size-1:0] a_exp_q, b_exp_q;
    logic [W-1:0]           big_q, small_q;
    logic [Exponent_Size-1:0] exp_q;
    logic                   swap_q;

    logic                   swap_c;
    logic [DIFF_W-1:0]      diff_c;
    logic [AMT_W-1:0]       rem_c;
    logic [W-1:0]           big_raw_c, small_raw_c;
    logic [Exponent_Size-1:0] big_exp_c;

    logic [W-1:0]           shift_in, shift_out;
    logic [AMT_W-1:0]       shift_amt;

`ifndef FPU_ALIGNER_BARREL_EN
    logic [AMT_W-1:0]       remaining_q;
    logic [AMT_W-1:0]       step_c;
`else
    logic                   unused_shift_step;
    assign unused_shift_step = |Shift_Step;
`endif

    // Operand selection and clamped exponent difference, from captured inputs.
    always_comb begin : compare_logic
        swap_c = (b_exp_q > a_exp_q);
        if (swap_c) begin
            diff_c      = {1'b0, b_exp_q} - {1'b0, a_exp_q};
            big_raw_c   = {b_mant_q, {GRS_BITS{1'b0}}};
            small_raw_c = {a_mant_q, {GRS_BITS{1'b0}}};
            big_exp_c   = b_exp_q;
        end else begin
            diff_c      = {1'b0, a_exp_q} - {1'b0, b_exp_q};
            big_raw_c   = {a_mant_q, {GRS_BITS{1'b0}}};
            small_raw_c = {b_mant_q, {GRS_BITS{1'b0}}};
            big_exp_c   = a_exp_q;
        end
        // Beyond W every mantissa bit ends up in sticky, so larger distances
        // are equivalent to W.
        if (32'(diff_c) >= 32'(W)) rem_c = AMT_W'(W);
        else                       rem_c = AMT_W'(diff_c);
    end

`ifndef FPU_ALIGNER_BARREL_EN
    assign step_c    = (remaining_q > AMT_W'(Shift_Step)) ? AMT_W'(Shift_Step) : remaining_q;
    assign shift_in  = small_q;
    assign shift_amt = step_c;
`else
    assign shift_in  = small_raw_c;
    assign shift_amt = rem_c;
`endif

    fpu_sticky_shifter #(
        .W     (W),
        .AMT_W (AMT_W)
    ) u_shifter (
        .value  (shift_in),
        .amount (shift_amt),
        .result (shift_out)
    );

    // FSM: state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (in_valid) state_d = ST_COMPARE;
`ifndef FPU_ALIGNER_BARREL_EN
            ST_COMPARE: state_d = (rem_c != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT:   if (remaining_q == step_c) state_d = ST_DONE;
`else
            ST_COMPARE: state_d = ST_DONE;
`endif
            ST_DONE:    if (out_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath registers. Nothing changes in DONE, which holds the result
    // stable under backpressure.
    // NOTE: the datapath flops are reset too, because the result outputs are
    // required to read zero while reset is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mant_q    <= '0;
            b_mant_q    <= '0;
            a_exp_q     <= '0;
            b_exp_q     <= '0;
            big_q       <= '0;
            small_q     <= '0;
            exp_q       <= '0;
            swap_q      <= 1'b0;
`ifndef FPU_ALIGNER_BARREL_EN
            remaining_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_mant_q <= a_mantissa;
                        b_mant_q <= b_mantissa;
                        a_exp_q  <= a_exponent;
                        b_exp_q  <= b_exponent;
                    end
                end
                ST_COMPARE: begin
                    big_q  <= big_raw_c;
                    exp_q  <= big_exp_c;
                    swap_q <= swap_c;
`ifndef FPU_ALIGNER_BARREL_EN
                    small_q     <= small_raw_c;
                    remaining_q <= rem_c;
`else
                    small_q     <= shift_out;
`endif
                end
`ifndef FPU_ALIGNER_BARREL_EN
                ST_SHIFT: begin
                    small_q     <= shift_out;
                    remaining_q <= remaining_q - step_c;
                end
`endif
                default: ;
            endcase
        end
    end

    assign big_mantissa    = big_q;
    assign small_mantissa  = small_q;
    assign common_exponent = exp_q;
    assign swapped         = swap_q;

endmodule : fpu_aligner

// File: tb/tb_fpu_aligner.sv
// -----------------------------------------------------------------------------
// tb_fpu_aligner
// Self-checking bench for fpu_aligner (Mantissa_Size=23, Exponent_Size=8,
// Shift_Step=4). Directed vectors with constant expectations, hand-written
// backpressure and mid-operation reset sequences, and randomized operands
// checked against an arithmetic reference model.
// Latency is counted in rising edges from the accepting edge (inclusive) up to
// the edge after which out_valid is first seen high.
// -----------------------------------------------------------------------------
module tb_fpu_aligner;

    localparam int MS = 23;
    localparam int ES = 8;
    localparam int SS = 4;
    localparam int W  = MS + 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [MS:0]   a_mantissa, b_mantissa;
    logic [ES-1:0] a_exponent, b_exponent;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  big_mantissa, small_mantissa;
    logic [ES-1:0] common_exponent;
    logic          swapped;

    fpu_aligner #(
        .Mantissa_Size (MS),
        .Exponent_Size (ES),
        .Shift_Step    (SS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a_mantissa      (a_mantissa),
        .a_exponent      (a_exponent),
        .b_mantissa      (b_mantissa),
        .b_exponent      (b_exponent),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .big_mantissa    (big_mantissa),
        .small_mantissa  (small_mantissa),
        .common_exponent (common_exponent),
        .swapped         (swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [MS:0]   am;
        logic [ES-1:0] ae;
        logic [MS:0]   bm;
        logic [ES-1:0] be;
        logic [W-1:0]  exp_big;
        logic [W-1:0]  exp_sml;
        logic [ES-1:0] exp_ce;
        logic          exp_sw;
    } vec_t;

    vec_t vecs[7];

    // Reference: pick the larger exponent, scale the other mantissa by 8 (GRS
    // room), divide by 2^d and set bit 0 if any remainder was lost.
    function automatic void model(input logic [MS:0] am, input logic [ES-1:0] ae,
                                  input logic [MS:0] bm, input logic [ES-1:0] be,
                                  output logic [W-1:0] big_o, output logic [W-1:0] sml_o,
                                  output logic [ES-1:0] ce_o, output logic sw_o,
                                  output int lat_o);
        longint s, r;
        int     d, rem;
        sw_o  = (be > ae);
        d     = sw_o ? (int'(be) - int'(ae)) : (int'(ae) - int'(be));
        ce_o  = sw_o ? be : ae;
        big_o = {(sw_o ? bm : am), 3'b000};
        s     = longint'(sw_o ? am : bm) * 8;
        if (d >= W) begin
            r = (s != 0) ? 1 : 0;
        end else begin
            r = s >> d;
            if (d > 0 && (s & ((longint'(1) << d) - 1)) != 0) r = r | 1;
        end
        sml_o = r[W-1:0];
        rem   = (d < W) ? d : W;
`ifdef FPU_ALIGNER_BARREL_EN
        lat_o = 2;
`else
        lat_o = 2 + (rem + SS - 1) / SS;
`endif
    endfunction

    // Called at a negedge with the DUT idle. Returns at the negedge where
    // out_valid is first seen (or the bound expired).
    task automatic do_op(input logic [MS:0] am, input logic [ES-1:0] ae,
                         input logic [MS:0] bm, input logic [ES-1:0] be,
                         output int lat, output logic tmo);
        a_mantissa = am; a_exponent = ae;
        b_mantissa = bm; b_exponent = be;
        in_valid   = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid   = 1'b0;
        // Scramble inputs: only the accepted values may matter.
        a_mantissa = MS'($urandom); a_exponent = ES'($urandom);
        b_mantissa = MS'($urandom); b_exponent = ES'($urandom);
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        tmo = !out_valid;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] eb, input logic [W-1:0] es,
                                input logic [ES-1:0] ece, input logic esw,
                                input int elat, input int lat, input logic tmo);
        check({tag, "_timeout"}, tmo, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_big"}, big_mantissa, eb);
        check({tag, "_small"}, small_mantissa, es);
        check({tag, "_exp"}, common_exponent, ece);
        check({tag, "_swapped"}, swapped, esw);
        check({tag, "_latency"}, lat, elat);
    endtask

    initial begin
        logic [W-1:0]  mb, msm;
        logic [ES-1:0] mce;
        logic          msw, tmo, seen;
        int            lat, mlat;
        logic [MS:0]   ram, rbm;
        logic [ES-1:0] rae, rbe;
        int            off;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_mantissa = '0; a_exponent = '0; b_mantissa = '0; b_exponent = '0;

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_big", big_mantissa, '0);
        check("rst_small", small_mantissa, '0);
        check("rst_exp", common_exponent, '0);
        check("rst_swapped", swapped, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{24'h800000, 8'd130, 24'hC00000, 8'd130, 27'h4000000, 27'h6000000, 8'd130, 1'b0};
        vecs[1] = '{24'h800000, 8'd130, 24'hC00001, 8'd125, 27'h4000000, 27'h0300001, 8'd130, 1'b0};
        vecs[2] = '{24'hFFFFFF, 8'd100, 24'h800000, 8'd101, 27'h4000000, 27'h3FFFFFC, 8'd101, 1'b1};
        vecs[3] = '{24'h800000, 8'd170, 24'hABCDEF, 8'd130, 27'h4000000, 27'h0000001, 8'd170, 1'b0};
        vecs[4] = '{24'h800000, 8'd170, 24'h000000, 8'd130, 27'h4000000, 27'h0000000, 8'd170, 1'b0};
        vecs[5] = '{24'h800000, 8'd30,  24'h800001, 8'd6,   27'h4000000, 27'h0000005, 8'd30,  1'b0};
        vecs[6] = '{24'h800000, 8'd0,   24'h800000, 8'd255, 27'h4000000, 27'h0000001, 8'd255, 1'b1};

        for (int i = 0; i < 7; i++) begin
            model(vecs[i].am, vecs[i].ae, vecs[i].bm, vecs[i].be, mb, msm, mce, msw, mlat);
            do_op(vecs[i].am, vecs[i].ae, vecs[i].bm, vecs[i].be, lat, tmo);
            check_result($sformatf("vec%0d", i), vecs[i].exp_big, vecs[i].exp_sml,
                         vecs[i].exp_ce, vecs[i].exp_sw, mlat, lat, tmo);
            release_out();
            check($sformatf("vec%0d_back_idle", i), in_ready, 1'b1);
        end

        // Backpressure: hold out_ready low 5 cycles while offering a new pair.
        do_op(vecs[2].am, vecs[2].ae, vecs[2].bm, vecs[2].be, lat, tmo);
        check("bp_timeout", tmo, 1'b0);
        for (int c = 0; c < 5; c++) begin
            a_mantissa = vecs[0].am; a_exponent = vecs[0].ae;
            b_mantissa = vecs[0].bm; b_exponent = vecs[0].be;
            in_valid   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d_valid", c), out_valid, 1'b1);
            check($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
            check($sformatf("bp%0d_big", c), big_mantissa, vecs[2].exp_big);
            check($sformatf("bp%0d_small", c), small_mantissa, vecs[2].exp_sml);
            check($sformatf("bp%0d_exp", c), common_exponent, vecs[2].exp_ce);
            check($sformatf("bp%0d_swapped", c), swapped, vecs[2].exp_sw);
        end
        in_valid = 1'b0;
        release_out();
        check("bp_release_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("bp_no_phantom_op", seen, 1'b0);
        check("bp_result_kept", small_mantissa, vecs[2].exp_sml);

        // Mid-operation reset (diff 8: two SHIFT cycles in the iterative build).
        a_mantissa = 24'h800000; a_exponent = 8'd130;
        b_mantissa = 24'hC00001; b_exponent = 8'd122;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
`ifndef FPU_ALIGNER_BARREL_EN
        repeat (2) @(posedge clk);
        #1;
`endif
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", in_ready, 1'b1);
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_big", big_mantissa, '0);
        check("rst_mid_small", small_mantissa, '0);
        check("rst_mid_exp", common_exponent, '0);
        check("rst_mid_swapped", swapped, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("rst_mid_no_pulse", seen, 1'b0);
        model(vecs[1].am, vecs[1].ae, vecs[1].bm, vecs[1].be, mb, msm, mce, msw, mlat);
        do_op(vecs[1].am, vecs[1].ae, vecs[1].bm, vecs[1].be, lat, tmo);
        check_result("post_rst", vecs[1].exp_big, vecs[1].exp_sml, vecs[1].exp_ce,
                     vecs[1].exp_sw, mlat, lat, tmo);
        release_out();

        // Randomized operands against the reference model.
        for (int i = 0; i < 300; i++) begin
            ram = {1'b1, 23'($urandom)};
            rbm = {1'b1, 23'($urandom)};
            if ($urandom_range(0, 9) == 0) rbm = '0;
            if ($urandom_range(0, 9) == 0) ram = '0;
            rae = ES'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rbe = ES'($urandom);
            end else begin
                off = int'(rae) + $signed($urandom_range(0, 70)) - 35;
                if (off < 0)   off = 0;
                if (off > 255) off = 255;
                rbe = ES'(off);
            end
            model(ram, rae, rbm, rbe, mb, msm, mce, msw, mlat);
            do_op(ram, rae, rbm, rbe, lat, tmo);
            check_result($sformatf("rnd%0d", i), mb, msm, mce, msw, mlat, lat, tmo);
            release_out();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fpu_aligner
